// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the eight-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_enc8
// Description : Rotated priority encoder; picks the first set request at or above ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_enc8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_off;

    // Rotate right by ptr so the highest-priority requester lands in bit 0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    always_comb begin
        w_off = '0;
        casez (w_rot)
            8'b???????1: w_off = 3'd0;
            8'b??????10: w_off = 3'd1;
            8'b?????100: w_off = 3'd2;
            8'b????1000: w_off = 3'd3;
            8'b???10000: w_off = 3'd4;
            8'b??100000: w_off = 3'd5;
            8'b?1000000: w_off = 3'd6;
            8'b10000000: w_off = 3'd7;
            default:     w_off = 3'd0;
        endcase
    end

    assign any = |req;
    assign idx = w_off + ptr;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : Eight-requester round-robin arbiter with release and hold-limit timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state,     w_state;
    logic [IDX_W-1:0] r_ptr,       w_ptr;
    logic [CNT_W-1:0] r_cnt,       w_cnt;
    logic [NREQ-1:0]  r_gnt,       w_gnt;
    logic [IDX_W-1:0] r_gnt_id,    w_gnt_id;
    logic             r_gnt_valid, w_gnt_valid;
    logic             r_timeout,   w_timeout;

    logic             w_any;
    logic [IDX_W-1:0] w_win;
    logic             w_owner_req;
    logic             w_at_limit;

    rr_prio_enc8 u_enc (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_win)
    );

    assign w_owner_req = req[r_gnt_id];
    assign w_at_limit  = (r_cnt == C_HOLD_LAST);

    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_cnt       = r_cnt;
        w_gnt       = r_gnt;
        w_gnt_id    = r_gnt_id;
        w_gnt_valid = r_gnt_valid;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state     = GRANT;
                    w_gnt       = NREQ'(1) << w_win;
                    w_gnt_id    = w_win;
                    w_gnt_valid = 1'b1;
                    w_ptr       = w_win + IDX_W'(1);
                    w_cnt       = '0;
                end
            end
            GRANT: begin
                if (done || !w_owner_req || w_at_limit) begin
                    w_state     = IDLE;
                    w_gnt       = '0;
                    w_gnt_id    = '0;
                    w_gnt_valid = 1'b0;
                    // Only a release caused purely by the hold limit is a timeout.
                    w_timeout   = !done && w_owner_req;
                end else if (!w_at_limit) begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_cnt       <= w_cnt;
            r_gnt       <= w_gnt;
            r_gnt_id    <= w_gnt_id;
            r_gnt_valid <= w_gnt_valid;
            r_timeout   <= w_timeout;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing a single resource among eight requesters. It resolves simultaneous requests through a rotated priority-encode stage, holds the grant until the owner releases it or a hold limit expires, and then advances priority past the last winner. The block sits between the eight requesting units and the shared resource; `gnt_id` drives the resource's select mux directly.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum cycles a grant may be held; legal range 1..255.
- `CNT_W`, default 8: hold-counter width; must satisfy MAX_HOLD ≤ 2^CNT_W − 1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  8  request vector; bit i is requester i, level-sensitive.
- `done`  in  1  release strobe from the current owner; ignored in IDLE.
- `gnt`  out  8  one-hot grant, registered; all zeros when no grant.
- `gnt_id`  out  3  binary index of the granted requester; 0 when no grant.
- `gnt_valid`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Two-state FSM: IDLE, GRANT.
- Pointer `ptr[2:0]` gives the highest-priority index. Priority order is ptr, ptr+1, …, ptr+7, all mod 8.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select winner w = first set bit of req scanning upward from ptr with wrap.
  - Load gnt = 1<<w, gnt_id = w, gnt_valid = 1; set ptr = (w+1) mod 8; clear the hold counter; go to GRANT.
- GRANT, release conditions, evaluated each cycle in priority order:
  1. `done` = 1 → normal release.
  2. `req[gnt_id]` = 0 → owner withdrew; normal release.
  3. Hold counter reaches MAX_HOLD−1 → forced release; pulse `timeout` = 1 in the next cycle, coincident with gnt_valid = 0.
- On any release:
  - Next cycle: gnt = 0, gnt_id = 0, gnt_valid = 0; state returns to IDLE.
  - Arbitration resumes in the following cycle.
- Without a release, the hold counter increments by 1 each GRANT cycle and saturates at MAX_HOLD−1.
- Changes to `req` on bits other than the owner's have no effect during GRANT.
- `done` together with the counter limit in the same cycle counts as a normal release; `timeout` stays 0.
- Arithmetic:
  - Rotation and the index add are 3-bit, wrapping mod 8.
  - The counter is CNT_W bits, unsigned.

## Timing
- Reset values (one edge with rst = 1):
  - State = IDLE, ptr = 0, counter = 0.
  - gnt = 8'h00, gnt_id = 3'd0, gnt_valid = 0, timeout = 0.
- `rst` overrides everything, including mid-grant. The grant drops on the edge that samples rst = 1, and `timeout` does not fire.
- Grant latency: req sampled in IDLE at edge k gives gnt_valid = 1 after edge k (visible in cycle k+1).
- Release latency: release sampled at edge k gives gnt_valid = 0 in cycle k+1. The earliest next grant is visible in cycle k+2. Each handover therefore has exactly one idle cycle.
- Maximum hold: gnt_valid stays high for MAX_HOLD cycles, then `timeout` is high for 1 cycle.
- Starvation bound: a requester holding req continuously is granted within 7 × (MAX_HOLD+1) + 1 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `arb_pkg`:
  - State enum: IDLE = 1'b0, GRANT = 1'b1.
  - Constants NREQ = 8, IDX_W = 3.
- Sub-module `rr_prio_enc8`, combinational:
  - Inputs req[7:0] and ptr[2:0]; outputs any, idx[2:0].
  - Rotate req right by ptr, take the lowest set bit by casez, then add ptr mod 8.
  - It is the only combinational logic outside the FSM next-state logic.
- Top module: FSM register, ptr register, hold counter, output registers.

## Test plan
- Reset, then req = 8'h00 for 5 cycles → gnt = 0, gnt_valid = 0, timeout = 0 throughout.
- After reset, req = 8'hFF with `done` pulsed one cycle after each grant → grant order is ids 0,1,2,…,7,0, with gnt_valid low for exactly one cycle between grants.
- ptr = 5 (previous winner was 4), req = 8'b0000_1001 → grant id 0 (wrap past 5,6,7); ptr becomes 1; next grant goes to id 3.
- Single req = 8'h04 held, `done` never asserted, MAX_HOLD = 16 → gnt = 8'h04 for 16 cycles, then gnt = 0 with timeout = 1 for one cycle, then re-granted id 2 one cycle later.
- Owner id 6 drops req[6] while req[1] stays high → gnt_valid falls the next cycle and id 1 is granted one cycle after that; `done` and counter limit asserted together → no timeout pulse.
- rst asserted during GRANT with id 3 held → next cycle gnt = 0 and ptr = 0; after rst falls, req = 8'h88 → id 3 is granted.
